alu_op_scheduler: RTL and testbench
===================================

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 SHALL have parameter OPW, default 3, operand width in bits.
REQ-002 SHALL have parameter RESW, default 6 (2*OPW), result width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req_valid, input, 2, one bit per requester: request present.
REQ-006 SHALL have ports req_ready, output, 2, one bit per requester: request accepted this cycle.
REQ-007 SHALL have ports req0_a/req0_b and req1_a/req1_b, input, OPW each, operands per requester.
REQ-008 SHALL have ports req0_op/req1_op, input, 2, opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 SHALL have port rsp_valid, output, 1, result available.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-012 SHALL have port rsp_result, output, RESW, operation result.
REQ-013 SHALL have port rsp_err, output, 1, divide-by-zero flag.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-016 IDLE: if any req_valid is high, SHALL grant one port, pulse its req_ready for that cycle only, capture its a/b/op/id, and go to EXEC.
REQ-017 req_ready SHALL be combinational from state, req_valid and priority; it is never high outside IDLE and at most one bit is high.
REQ-018 Arbitration SHALL be round-robin: port 0 has priority after reset; after a grant to port i, priority goes to the other port.
REQ-019 A lone valid request SHALL be granted regardless of priority.
REQ-020 Add/sub SHALL spend exactly 1 EXEC cycle; mul/div SHALL spend exactly OPW EXEC cycles, one bit per cycle.
REQ-021 Latency SHALL be: accept at cycle T gives rsp_valid at T+2 (add/sub) or T+1+OPW (mul/div).
REQ-022 Add SHALL give a+b zero-extended to RESW bits; sub SHALL give (a-b) mod 2^RESW.
REQ-023 Mul SHALL use iterative shift-add, giving the unsigned product a*b in RESW bits.
REQ-024 Div SHALL use restoring division, giving rsp_result = {remainder, quotient}: quotient in [OPW-1:0], remainder in [RESW-1:OPW].
REQ-025 Div with b=0 SHALL give quotient all-ones and remainder a, with rsp_err=1; rsp_err SHALL be 0 for every other case.
REQ-026 DONE: rsp_valid, rsp_id, rsp_result and rsp_err SHALL be held stable until the cycle in which rsp_ready=1; the FSM then returns to IDLE.
REQ-027 No new request SHALL be accepted in the cycle DONE completes; the next grant is no earlier than the following IDLE cycle.
REQ-028 req_valid and operand changes during EXEC/DONE SHALL NOT affect the operation in flight.

Reset
REQ-029 On rst=1, the FSM SHALL go to IDLE and priority SHALL go to port 0.
REQ-030 On rst=1, outputs SHALL be req_ready=00, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
REQ-031 Reset mid-EXEC or mid-DONE SHALL discard the operation, with no response issued.

Structure
REQ-032 Package alu_seq_pkg SHALL hold the opcode enum, the FSM state enum and the OPW/RESW defaults.
REQ-033 The mul/div iteration datapath (accumulator, shifter, bit counter) SHALL be sub-module alu_iter_core; arbitration, FSM and the add/sub path stay in the top.

Verification
REQ-034 Port0 add a=7, b=7 at cycle T -> rsp_valid at T+2, result=14, id=0, err=0.
REQ-035 Port1 mul a=7, b=5 -> rsp_valid at T+4, result=35, id=1; port0 sub a=2, b=5 -> result=61.
REQ-036 Div a=7, b=2 -> result=11 (r=1, q=3), err=0; div a=5, b=0 -> result=47 (r=5, q=7), err=1.
REQ-037 Both ports valid continuously after reset -> grants alternate 0,1,0,1; req_ready never has both bits high.
REQ-038 rsp_ready held low 5 cycles in DONE -> outputs stable, busy=1, req_ready=00; release -> IDLE, next grant the cycle after.
REQ-039 rst asserted during the 2nd EXEC cycle of a mul -> next cycle IDLE, all outputs at reset values, no rsp_valid pulse.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the two-port ALU operation scheduler.
package alu_seq_pkg;

    localparam int unsigned OPW_DEF  = 3;
    localparam int unsigned RESW_DEF = 2 * OPW_DEF;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpMul = 2'b10,
        OpDiv = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Bit-serial multiply (shift-add) and restoring divide; one operand bit per cycle.
module alu_iter_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned OPW  = OPW_DEF,
    parameter int unsigned RESW = RESW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_div,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    output logic            last,
    output logic [RESW-1:0] result
);

    localparam int unsigned CW = $clog2(OPW + 1);

    logic [RESW-1:0] acc_q;
    logic [RESW-1:0] mcand_q;
    logic [OPW-1:0]  sh_q;
    logic [OPW-1:0]  rem_q;
    logic [OPW-1:0]  dsr_q;
    logic            div_q;
    logic [CW-1:0]   cnt_q;

    logic [OPW:0]    rem_sh;
    logic            rem_fits;
    logic [OPW-1:0]  rem_nx;

    // The partial remainder always ends below 2^OPW, so the subtraction can be truncated.
    always_comb begin
        rem_sh   = {rem_q, sh_q[OPW-1]};
        rem_fits = (rem_sh >= {1'b0, dsr_q});
        rem_nx   = rem_fits ? (rem_sh[OPW-1:0] - dsr_q) : rem_sh[OPW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (start) begin
            acc_q   <= '0;
            mcand_q <= RESW'(a);
            sh_q    <= is_div ? a : b;
            rem_q   <= '0;
            dsr_q   <= b;
            div_q   <= is_div;
            cnt_q   <= CW'(OPW);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            if (div_q) begin
                // Dividend bits leave at the top while quotient bits enter at the bottom.
                rem_q <= rem_nx;
                sh_q  <= (sh_q << 1) | OPW'(rem_fits);
            end else begin
                if (sh_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q <= mcand_q << 1;
                sh_q    <= sh_q >> 1;
            end
        end
    end

    always_comb begin
        last   = (cnt_q == CW'(1));
        result = div_q ? ((RESW'(rem_q) << OPW) | RESW'(sh_q)) : acc_q;
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin front end that runs one ALU operation at a time.
module alu_op_scheduler
    import alu_seq_pkg::*;
#(
    parameter int unsigned OPW  = OPW_DEF,
    parameter int unsigned RESW = RESW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    input  logic [1:0]      req0_op,
    input  logic [1:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [RESW-1:0] rsp_result,
    output logic            rsp_err,
    output logic            busy
);

    state_e          state_q;
    op_e             op_q;
    logic            id_q;
    logic            prio_q;
    logic            err_q;
    logic [RESW-1:0] addsub_q;

    logic            gnt_id;
    logic            accept;
    logic [OPW-1:0]  sel_a;
    logic [OPW-1:0]  sel_b;
    op_e             sel_op;
    logic            sel_iter;
    logic            op_iter;
    logic            core_last;
    logic [RESW-1:0] core_result;

    // A lone request wins outright; contention is resolved by prio_q.
    always_comb begin
        gnt_id    = req_valid[1] & (~req_valid[0] | prio_q);
        accept    = (state_q == StIdle) & (|req_valid) & ~rst;
        req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        sel_a     = gnt_id ? req1_a : req0_a;
        sel_b     = gnt_id ? req1_b : req0_b;
        sel_op    = op_e'(gnt_id ? req1_op : req0_op);
        sel_iter  = (sel_op == OpMul) || (sel_op == OpDiv);
        op_iter   = (op_q == OpMul) || (op_q == OpDiv);
    end

    alu_iter_core #(
        .OPW  (OPW),
        .RESW (RESW)
    ) u_iter_core (
        .clk    (clk),
        .rst    (rst),
        .start  (accept & sel_iter),
        .is_div (sel_op == OpDiv),
        .a      (sel_a),
        .b      (sel_b),
        .last   (core_last),
        .result (core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            op_q     <= OpAdd;
            err_q    <= 1'b0;
            addsub_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q  <= StExec;
                        prio_q   <= ~gnt_id;
                        id_q     <= gnt_id;
                        op_q     <= sel_op;
                        err_q    <= (sel_op == OpDiv) && (sel_b == '0);
                        addsub_q <= (sel_op == OpSub) ? (RESW'(sel_a) - RESW'(sel_b))
                                                      : (RESW'(sel_a) + RESW'(sel_b));
                    end
                end
                StExec: begin
                    if (!op_iter || core_last) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        rsp_valid  = (state_q == StDone);
        rsp_id     = rsp_valid & id_q;
        rsp_err    = rsp_valid & err_q;
        rsp_result = rsp_valid ? (op_iter ? core_result : addsub_q) : '0;
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench with a cycle-level behavioural model checked every cycle.
module tb_alu_op_scheduler;

    localparam int OPW  = 3;
    localparam int RESW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [OPW-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [1:0]      req0_op, req1_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [RESW-1:0] rsp_result;
    logic            rsp_err;
    logic            busy;

    alu_op_scheduler #(
        .OPW  (OPW),
        .RESW (RESW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [1:0]      obs_ready;
    logic            obs_valid, obs_id, obs_err, obs_busy;
    logic [RESW-1:0] obs_res;

    // Model: 0 = free, 1 = computing (m_cnt cycles left), 2 = holding a result.
    int m_phase = 0;
    int m_cnt   = 0;
    int m_prio  = 0;
    int m_res   = 0;
    int m_id    = 0;
    int m_err   = 0;

    int got, t_acc, ng, both, nv;
    int gids[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_op(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % (1 << RESW);
            1:       return (a - b + (1 << RESW)) % (1 << RESW);
            2:       return a * b;
            default: return (b == 0) ? (a << OPW) + ((1 << OPW) - 1) : ((a % b) << OPW) + a / b;
        endcase
    endfunction

    function automatic int model_grant();
        if (req_valid == 2'b11) return m_prio;
        return req_valid[1] ? 1 : 0;
    endfunction

    task automatic model_check();
        int exp_ready;
        if (rst) begin
            check("ready_during_rst", obs_ready, 0);
        end else begin
            exp_ready = 0;
            if (m_phase == 0 && req_valid != 2'b00) exp_ready = (model_grant() == 1) ? 2 : 1;
            check("req_ready", obs_ready, exp_ready);
            check("busy", obs_busy, m_phase != 0);
            check("rsp_valid", obs_valid, m_phase == 2);
            if (m_phase == 2) begin
                check("rsp_id", obs_id, m_id);
                check("rsp_result", obs_res, m_res);
                check("rsp_err", obs_err, m_err);
            end
        end
    endtask

    task automatic model_step();
        int g, op, a, b;
        if (rst) begin
            m_phase = 0;
            m_prio  = 0;
        end else begin
            case (m_phase)
                0: if (req_valid != 2'b00) begin
                    g       = model_grant();
                    op      = g ? int'(req1_op) : int'(req0_op);
                    a       = g ? int'(req1_a) : int'(req0_a);
                    b       = g ? int'(req1_b) : int'(req0_b);
                    m_res   = model_op(op, a, b);
                    m_err   = (op == 3 && b == 0) ? 1 : 0;
                    m_id    = g;
                    m_prio  = 1 - g;
                    m_cnt   = (op < 2) ? 1 : OPW;
                    m_phase = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        obs_ready = req_ready;
        obs_valid = rsp_valid;
        obs_res   = rsp_result;
        obs_id    = rsp_id;
        obs_err   = rsp_err;
        obs_busy  = busy;
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int port, input int op, input int a, input int b);
        if (port == 0) begin
            req0_op = 2'(op); req0_a = OPW'(a); req0_b = OPW'(b);
        end else begin
            req1_op = 2'(op); req1_a = OPW'(a); req1_b = OPW'(b);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ready"}, obs_ready, 0);
        check({name, "_busy"}, obs_busy, 0);
        check({name, "_valid"}, obs_valid, 0);
        check({name, "_result"}, obs_res, 0);
        check({name, "_id"}, obs_id, 0);
        check({name, "_err"}, obs_err, 0);
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("after_reset");
    endtask

    task automatic drain();
        req_valid = 2'b00;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!obs_busy) break;
        end
        check("drain_idle", obs_busy, 0);
    endtask

    task automatic run_op(input int port, input int op, input int a, input int b,
                          input int exp_res, input int exp_err, input int exp_lat,
                          input string name);
        set_port(port, op, a, b);
        req_valid = (port == 0) ? 2'b01 : 2'b10;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            tick();
            if (obs_ready[port]) got = 1;
        end
        check({name, "_granted"}, got, 1);
        t_acc = cyc;
        // Disturb the inputs while the operation is in flight.
        req_valid = 2'b00;
        set_port(port, (op + 1) % 4, (a + 3) % 8, (b + 5) % 8);
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            tick();
            if (obs_valid) got = 1;
        end
        check({name, "_rsp_seen"}, got, 1);
        check({name, "_latency"}, cyc - t_acc, exp_lat);
        check({name, "_result"}, obs_res, exp_res);
        check({name, "_id"}, obs_id, port);
        check({name, "_err"}, obs_err, exp_err);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        set_port(0, 0, 0, 0);
        set_port(1, 0, 0, 0);
        do_reset();

        run_op(0, 0, 7, 7, 14, 0, 2, "add_7_7");
        run_op(1, 2, 7, 5, 35, 0, 4, "mul_7_5");
        run_op(0, 1, 2, 5, 61, 0, 2, "sub_2_5");
        run_op(1, 3, 7, 2, 11, 0, 4, "div_7_2");
        run_op(0, 3, 5, 0, 47, 1, 4, "div_5_0");
        run_op(0, 2, 7, 7, 49, 0, 4, "mul_7_7");
        run_op(0, 3, 6, 4, 17, 0, 4, "div_6_4");
        run_op(1, 2, 6, 3, 18, 0, 4, "mul_6_3");
        run_op(1, 0, 0, 0, 0, 0, 2, "add_0_0");

        // Both ports requesting continuously from reset.
        do_reset();
        set_port(0, 0, 1, 2);
        set_port(1, 1, 6, 1);
        req_valid = 2'b11;
        ng = 0;
        both = 0;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            tick();
            if (obs_ready == 2'b11) both++;
            if (obs_ready != 2'b00) begin
                gids[ng] = int'(obs_ready[1]);
                ng++;
            end
        end
        check("rr_grant_count", ng, 4);
        check("rr_grant0", gids[0], 0);
        check("rr_grant1", gids[1], 1);
        check("rr_grant2", gids[2], 0);
        check("rr_grant3", gids[3], 1);
        check("rr_both_ready", both, 0);
        drain();

        // Consumer stalls in DONE while both ports keep requesting.
        rsp_ready = 1'b0;
        set_port(0, 0, 3, 4);
        req_valid = 2'b01;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            tick();
            if (obs_ready[0]) got = 1;
        end
        check("stall_granted", got, 1);
        req_valid = 2'b11;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            tick();
            if (obs_valid) got = 1;
        end
        check("stall_rsp_seen", got, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_valid", obs_valid, 1);
            check("stall_result", obs_res, 7);
            check("stall_busy", obs_busy, 1);
            check("stall_ready", obs_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("release_ready", obs_ready, 0);
        check("release_valid", obs_valid, 1);
        tick();
        check("grant_after_release", obs_ready, 2);
        drain();

        // Reset during the second EXEC cycle of a multiply.
        set_port(1, 2, 7, 5);
        req_valid = 2'b10;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            tick();
            if (obs_ready[1]) got = 1;
        end
        check("rst_mul_granted", got, 1);
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("mid_exec_reset");
        nv = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (obs_valid) nv++;
        end
        check("no_rsp_after_reset", nv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
